// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
package fetch_pkg;

    // RV32I canonical NOP (addi x0, x0, 0), injected into IF/ID on a flush.
    localparam logic [31:0] NOP = 32'h00000013;

    // RUN fetches normally; DROP waits to discard one wrong-path response.
    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } fetch_state_t;

    // Instruction together with its PC and the sequential successor PC.
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc1;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response handshake.
// A response is accepted when imem_req and imem_rvalid are high together.
interface fetch_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a fetched instruction that
// decode could not take. clear and unload both empty it; clear wins over load.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter type slot_t = fetch_slot_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  unload,
    input  logic  clear,
    input  slot_t din,
    output logic  valid,
    output slot_t dout
);

    // Single entry: emptied by a redirect or by handing the entry to decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear || unload) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage with a variable-latency memory
// handshake, a one-entry skid buffer and wrong-path response squashing.
// Optional feature: define FETCH_PERF_CNT_EN to add the perf_fetch and
// perf_stall counters as output ports.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               ILEN     = 32,
    parameter int               PC_STEP  = 1,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    input  logic            stall_d,
    input  logic            flush_d,
    fetch_if.master         imem,
    output logic [ILEN-1:0] if_id_ir,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc1,
    output logic            if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_stall
`endif
);

    localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);
    localparam logic [ILEN-1:0] NOP_I = ILEN'(NOP);

    typedef struct packed {
        logic [ILEN-1:0] ir;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc1;
    } slot_t;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] drop_addr;
    logic            req;
    logic            accepted;
    logic            pending;
    logic            take;
    logic            ifid_open;
    logic            to_ifid;
    logic            to_buf;
    logic            unload;
    logic            buf_valid;
    slot_t           mem_slot;
    slot_t           buf_slot;
    slot_t           if_id;
    logic            if_id_v;

    // A request is withdrawn during reset and while the skid buffer is full;
    // in DROP the stale address is re-presented until its response shows up.
    assign req            = !rst && ((state == DROP) || !buf_valid);
    assign imem.imem_req  = req;
    assign imem.imem_addr = (state == DROP) ? drop_addr : pc_f;

    assign accepted  = req && imem.imem_rvalid;
    assign pending   = req && !imem.imem_rvalid;
    // Only a RUN-state response with no redirect in the same cycle is kept.
    assign take      = accepted && (state == RUN) && !pc_src_e;
    assign ifid_open = !stall_d && !flush_d;
    assign to_ifid   = take && ifid_open && !buf_valid;
    assign to_buf    = take && !to_ifid;
    // Draining the buffer uses the cycle; no request is issued alongside it.
    assign unload    = buf_valid && ifid_open && !pc_src_e;
    assign mem_slot  = '{ir: imem.imem_rdata, pc: pc_f, pc1: pc_f + STEP};

    fetch_skid_buf #(
        .slot_t (slot_t)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (to_buf),
        .unload (unload),
        .clear  (pc_src_e),
        .din    (mem_slot),
        .valid  (buf_valid),
        .dout   (buf_slot)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Enter DROP when a redirect leaves an unanswered request in flight; leave
    // it once that response has been swallowed.
    always_comb begin
        state_next = state;
        if (pc_src_e) begin
            state_next = pending ? DROP : RUN;
        end else if ((state == DROP) && accepted) begin
            state_next = RUN;
        end
    end

    // PC advances per kept response; a redirect remembers the address still
    // owed by memory so it can be held on the bus while dropping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f      <= RESET_PC;
            drop_addr <= '0;
        end else begin
            if (pc_src_e) begin
                pc_f <= pc_target_e;
            end else if (take) begin
                pc_f <= pc_f + STEP;
            end
            if (pc_src_e && pending) begin
                drop_addr <= imem.imem_addr;
            end
        end
    end

    // IF/ID register: flush inserts a bubble (PCs hold), stall holds, and a
    // load takes the buffered entry before any fresh memory response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id   <= '{ir: NOP_I, pc: '0, pc1: '0};
            if_id_v <= 1'b0;
        end else if (flush_d) begin
            if_id.ir <= NOP_I;
            if_id_v  <= 1'b0;
        end else if (unload) begin
            if_id   <= buf_slot;
            if_id_v <= 1'b1;
        end else if (to_ifid) begin
            if_id   <= mem_slot;
            if_id_v <= 1'b1;
        end
    end

    assign if_id_ir    = if_id.ir;
    assign if_id_pc    = if_id.pc;
    assign if_id_pc1   = if_id.pc1;
    assign if_id_valid = if_id_v;

`ifdef FETCH_PERF_CNT_EN
    // Count kept responses and cycles lost to memory wait or decode backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (take) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if (pending || (buf_valid && stall_d)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit. A transaction-level
// model predicts bus and IF/ID outputs each cycle; a negedge monitor compares.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc1;
    } slot_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        slot_t       ifid;
        logic        valid;
        logic [31:0] pf;
        logic [31:0] ps;
    } snap_t;

    logic        clk;
    logic        rst;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc1;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    fetch_if #(.XLEN(32), .ILEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .ILEN     (32),
        .PC_STEP  (1),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .imem        (bus),
        .if_id_ir    (if_id_ir),
        .if_id_pc    (if_id_pc),
        .if_id_pc1   (if_id_pc1),
        .if_id_valid (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and counters.
    snap_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    mon_cycle = 0;

    // Reference model state: the architectural fetch stream.
    logic [31:0] m_pc;
    bit          m_drop;
    logic [31:0] m_drop_addr;
    slot_t       m_held[$];
    slot_t       m_ifid;
    bit          m_valid;
    logic [31:0] m_pf;
    logic [31:0] m_ps;

    // Memory responder state.
    int mode = 0;
    int wait_cnt = 0;
    int cur_lat = 0;

    function automatic int pickLat();
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic modelReset();
        m_pc        = 32'h0;
        m_drop      = 1'b0;
        m_drop_addr = 32'h0;
        m_held.delete();
        m_ifid      = '{ir: NOP, pc: 32'h0, pc1: 32'h0};
        m_valid     = 1'b0;
        m_pf        = 32'h0;
        m_ps        = 32'h0;
    endtask

    // Drive one cycle of inputs, publish the expected outputs for that cycle,
    // then advance the model across the next clock edge.
    task automatic applyStimulus(input bit r, input bit src, input logic [31:0] tgt,
                                 input bit stl, input bit fl);
        snap_t       e;
        bit          req;
        bit          rv;
        bit          got;
        bit          fresh;
        bit          direct;
        logic [31:0] addr;
        logic [31:0] rd;
        slot_t       s;
        @(posedge clk);
        #1;
        rst         = r;
        pc_src_e    = src;
        pc_target_e = tgt;
        stall_d     = stl;
        flush_d     = fl;
        if (r) begin
            modelReset();
            wait_cnt = 0;
            cur_lat  = pickLat();
        end
        req  = !r && (m_drop || m_held.size() == 0);
        addr = m_drop ? m_drop_addr : m_pc;
        rv   = req && (wait_cnt >= cur_lat);
        rd   = addr + 32'h100;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;

        e.req   = req;
        e.addr  = addr;
        e.ifid  = m_ifid;
        e.valid = m_valid;
        e.pf    = m_pf;
        e.ps    = m_ps;
        sb.push_back(e);

        if (!r) begin
            got    = req && rv;
            fresh  = got && !m_drop && !src;
            direct = 1'b0;
            s      = '{ir: rd, pc: addr, pc1: addr + 32'd1};
            if ((req && !rv) || (m_held.size() > 0 && stl)) m_ps = m_ps + 32'd1;
            if (fresh) m_pf = m_pf + 32'd1;
            if (fl) begin
                m_ifid.ir = NOP;
                m_valid   = 1'b0;
            end else if (!stl && !src) begin
                if (m_held.size() > 0) begin
                    m_ifid  = m_held.pop_front();
                    m_valid = 1'b1;
                end else if (fresh) begin
                    m_ifid  = s;
                    m_valid = 1'b1;
                    direct  = 1'b1;
                end
            end
            if (src) begin
                m_held.delete();
                if (req && !rv) begin
                    m_drop      = 1'b1;
                    m_drop_addr = addr;
                end else begin
                    m_drop = 1'b0;
                end
                m_pc = tgt;
            end else if (got && m_drop) begin
                m_drop = 1'b0;
            end else if (fresh) begin
                if (!direct) m_held.push_back(s);
                m_pc = m_pc + 32'd1;
            end
            if (req) begin
                if (rv) begin
                    wait_cnt = 0;
                    cur_lat  = pickLat();
                end else begin
                    wait_cnt++;
                end
            end
        end
    endtask

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, mon_cycle, got, want);
        end
    endtask

    task automatic checkOutput(input snap_t e);
        compare("imem_req", 32'(bus.imem_req), 32'(e.req));
        if (e.req) compare("imem_addr", bus.imem_addr, e.addr);
        compare("if_id_valid", 32'(if_id_valid), 32'(e.valid));
        compare("if_id_ir", if_id_ir, e.ifid.ir);
        compare("if_id_pc", if_id_pc, e.ifid.pc);
        compare("if_id_pc1", if_id_pc1, e.ifid.pc1);
`ifdef FETCH_PERF_CNT_EN
        compare("perf_fetch", perf_fetch, e.pf);
        compare("perf_stall", perf_stall, e.ps);
`endif
    endtask

    // Monitor: away from the active edge, pop the expectation for this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            checkOutput(sb.pop_front());
            mon_cycle++;
        end
    end

    initial begin
        rst             = 1'b1;
        pc_src_e        = 1'b0;
        pc_target_e     = 32'h0;
        stall_d         = 1'b0;
        flush_d         = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        modelReset();

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);

        $display("[TB] zero-wait stream");
        mode = 0;
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] one wait cycle per request");
        mode = 1;
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] decode stall into skid buffer");
        mode = 0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] redirect with request outstanding");
        mode = 1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h40, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] flush with stall");
        applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] pc wrap");
        mode = 0;
        applyStimulus(0, 1, 32'hFFFF_FFFE, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          src;
            logic [31:0] tgt;
            if (i % 250 == 0) mode = int'($urandom_range(0, 2));
            r   = ($urandom_range(0, 399) == 0);
            src = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) tgt = {28'hFFF_FFFF, 4'($urandom_range(0, 15))};
            else tgt = 32'($urandom_range(0, 255));
            applyStimulus(r, src, tgt, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        #1;
        compare("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
